gsm_wr_sched: RTL and testbench

GSM_WR_SCHED -- requirements
Module: gsm_wr_sched

---
 rtl/gsm_wr_sched.sv | 122 ++++++++++++
 tb/tb_gsm_wr_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gsm_wr_sched.sv
// Group write-port scheduler: round-robin arbitration among GSIZE requesters,
// packet locking from header to last cell, and free-cell accounting.
//
// state | meaning
// IDLE  | no packet in flight; next grant goes to a header cell, round-robin
// LOCK  | holder owns the write port until it sends its last cell
module gsm_wr_sched #(
   parameter int GSIZE     = 4,
   parameter int LOG_GSIZE = 2,
   parameter int AWIDTH    = 7
) (
   input  logic                 clk_80M,
   input  logic                 rst_n,
   input  logic [GSIZE-1:0]     i_req,
   input  logic [GSIZE-1:0]     i_sop,
   input  logic [GSIZE-1:0]     i_eop,
   input  logic                 i_free,
   output logic [GSIZE-1:0]     o_grant,
   output logic                 o_wr_en,
   output logic [LOG_GSIZE-1:0] o_wr_sel,
   output logic [AWIDTH-1:0]    o_wr_addr,
   output logic [AWIDTH:0]      o_free_cnt,
   output logic                 o_full,
   output logic                 o_busy
);

   localparam logic [AWIDTH:0] CELLS = {1'b1, {AWIDTH{1'b0}}};

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t                 state, state_nxt;
   logic [LOG_GSIZE-1:0]   holder, holder_nxt;
   logic [LOG_GSIZE-1:0]   rr_ptr, rr_nxt;
   logic [AWIDTH-1:0]      addr_cnt;
   logic [LOG_GSIZE-1:0]   gnt_idx;
   logic [LOG_GSIZE-1:0]   idx;
   logic                   gnt_any;

   // Index arithmetic wraps naturally because GSIZE == 2**LOG_GSIZE.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      o_grant = '0;
      if (rst_n && (o_free_cnt != '0)) begin
         if (state == LOCK) begin
            if (i_req[holder]) begin
               gnt_any = 1'b1;
               gnt_idx = holder;
            end
         end else begin
            for (int i = 0; i < GSIZE; i++) begin
               idx = rr_ptr + LOG_GSIZE'(i);
               if (!gnt_any && i_req[idx] && i_sop[idx]) begin
                  gnt_any = 1'b1;
                  gnt_idx = idx;
               end
            end
         end
         if (gnt_any) o_grant[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      holder_nxt = holder;
      rr_nxt     = rr_ptr;
      case (state)
         IDLE: begin
            if (gnt_any) begin
               if (i_eop[gnt_idx]) begin
                  rr_nxt = gnt_idx + LOG_GSIZE'(1);
               end else begin
                  state_nxt  = LOCK;
                  holder_nxt = gnt_idx;
               end
            end
         end
         LOCK: begin
            if (gnt_any && i_eop[holder]) begin
               state_nxt = IDLE;
               rr_nxt    = holder + LOG_GSIZE'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_80M) begin
      if (!rst_n) begin
         state      <= IDLE;
         holder     <= '0;
         rr_ptr     <= '0;
         addr_cnt   <= '0;
         o_free_cnt <= CELLS;
         o_wr_en    <= 1'b0;
         o_wr_sel   <= '0;
         o_wr_addr  <= '0;
      end else begin
         state   <= state_nxt;
         holder  <= holder_nxt;
         rr_ptr  <= rr_nxt;
         o_wr_en <= gnt_any;
         if (gnt_any) begin
            o_wr_sel  <= gnt_idx;
            o_wr_addr <= addr_cnt;
            addr_cnt  <= addr_cnt + AWIDTH'(1);
         end
         // A release in the same cycle as a grant cancels out; a release
         // with every cell already free is dropped.
         if (gnt_any && !i_free) begin
            o_free_cnt <= o_free_cnt - (AWIDTH+1)'(1);
         end else if (!gnt_any && i_free && (o_free_cnt != CELLS)) begin
            o_free_cnt <= o_free_cnt + (AWIDTH+1)'(1);
         end
      end
   end

   assign o_full = (o_free_cnt == '0);
   assign o_busy = (state == LOCK);

endmodule

// File: tb/tb_gsm_wr_sched.sv
// Directed bench for gsm_wr_sched: vector table for arbitration and locking,
// plus hand sequences for fill/wrap, counter saturation and reset mid-packet.
module tb_gsm_wr_sched;

   logic       clk_80M = 1'b0;
   logic       rst_n;
   logic [3:0] i_req, i_sop, i_eop;
   logic       i_free;
   logic [3:0] o_grant;
   logic       o_wr_en;
   logic [1:0] o_wr_sel;
   logic [6:0] o_wr_addr;
   logic [7:0] o_free_cnt;
   logic       o_full, o_busy;

   int tests = 0;
   int fails = 0;

   gsm_wr_sched #(.GSIZE(4), .LOG_GSIZE(2), .AWIDTH(7)) dut (
      .clk_80M(clk_80M), .rst_n(rst_n),
      .i_req(i_req), .i_sop(i_sop), .i_eop(i_eop), .i_free(i_free),
      .o_grant(o_grant), .o_wr_en(o_wr_en), .o_wr_sel(o_wr_sel),
      .o_wr_addr(o_wr_addr), .o_free_cnt(o_free_cnt),
      .o_full(o_full), .o_busy(o_busy)
   );

   always #5 clk_80M = ~clk_80M;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] sop;
      logic [3:0] eop;
      logic       free;
      logic [3:0] grant;
      logic       busy;
      logic [7:0] fcnt;
   } vec_t;

   vec_t tbl [0:19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock, then drive inputs and let combinational outputs settle.
   task automatic apply(input logic [3:0] req, input logic [3:0] sop,
                        input logic [3:0] eop, input logic free);
      @(posedge clk_80M);
      #1;
      i_req  = req;
      i_sop  = sop;
      i_eop  = eop;
      i_free = free;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply(4'h0, 4'h0, 4'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
      return r;
   endfunction

   logic [3:0] prev_gnt;
   logic [6:0] amodel;

   initial begin
      // req    sop    eop    free  grant  busy  fcnt
      tbl[0]  = '{4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 1'b0, 8'd128};
      tbl[1]  = '{4'hF, 4'hF, 4'hF, 1'b0, 4'h2, 1'b0, 8'd127};
      tbl[2]  = '{4'hF, 4'hF, 4'hF, 1'b0, 4'h4, 1'b0, 8'd126};
      tbl[3]  = '{4'hF, 4'hF, 4'hF, 1'b0, 4'h8, 1'b0, 8'd125};
      tbl[4]  = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd124};
      tbl[5]  = '{4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 8'd124};
      tbl[6]  = '{4'h2, 4'h2, 4'h2, 1'b0, 4'h2, 1'b0, 8'd124};
      tbl[7]  = '{4'hF, 4'hF, 4'hB, 1'b0, 4'h4, 1'b0, 8'd123};
      tbl[8]  = '{4'hF, 4'hB, 4'hB, 1'b0, 4'h4, 1'b1, 8'd122};
      tbl[9]  = '{4'hF, 4'hB, 4'hF, 1'b0, 4'h4, 1'b1, 8'd121};
      tbl[10] = '{4'hB, 4'hB, 4'hB, 1'b0, 4'h8, 1'b0, 8'd120};
      tbl[11] = '{4'h2, 4'h2, 4'h0, 1'b0, 4'h2, 1'b0, 8'd119};
      tbl[12] = '{4'h3, 4'h1, 4'h0, 1'b0, 4'h2, 1'b1, 8'd118};
      tbl[13] = '{4'h1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b1, 8'd117};
      tbl[14] = '{4'h1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b1, 8'd117};
      tbl[15] = '{4'h3, 4'h1, 4'h2, 1'b0, 4'h2, 1'b1, 8'd117};
      tbl[16] = '{4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b0, 8'd116};
      tbl[17] = '{4'h4, 4'h4, 4'h4, 1'b1, 4'h4, 1'b0, 8'd115};
      tbl[18] = '{4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 8'd115};
      tbl[19] = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd116};

      // Reset values, with grant suppressed while reset is held
      rst_n = 1'b0; i_req = 4'hF; i_sop = 4'hF; i_eop = 4'hF; i_free = 1'b0;
      #2;
      chk("grant_in_reset", o_grant, 4'h0);
      @(posedge clk_80M); #1;
      chk("rst_grant", o_grant, 4'h0);
      chk("rst_free_cnt", o_free_cnt, 8'd128);
      chk("rst_wr_en", o_wr_en, 1'b0);
      chk("rst_wr_sel", o_wr_sel, 2'd0);
      chk("rst_wr_addr", o_wr_addr, 7'd0);
      chk("rst_full", o_full, 1'b0);
      chk("rst_busy", o_busy, 1'b0);

      // Vector table: round-robin, sop gating, packet lock, stalls, free accounting
      do_reset();
      prev_gnt = 4'h0;
      amodel   = 7'd0;
      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].req, tbl[i].sop, tbl[i].eop, tbl[i].free);
         chk($sformatf("v%0d_grant", i), o_grant, tbl[i].grant);
         chk($sformatf("v%0d_busy", i), o_busy, tbl[i].busy);
         chk($sformatf("v%0d_free_cnt", i), o_free_cnt, tbl[i].fcnt);
         chk($sformatf("v%0d_wr_en", i), o_wr_en, (prev_gnt != 4'h0));
         if (prev_gnt != 4'h0) begin
            chk($sformatf("v%0d_wr_sel", i), o_wr_sel, oh2idx(prev_gnt));
            chk($sformatf("v%0d_wr_addr", i), o_wr_addr, amodel);
            amodel++;
         end
         prev_gnt = tbl[i].grant;
      end

      // Release with all cells free is dropped
      do_reset();
      apply(4'h0, 4'h0, 4'h0, 1'b1);
      apply(4'h0, 4'h0, 4'h0, 1'b0);
      chk("free_at_max", o_free_cnt, 8'd128);

      // Grant and release together at 50 free cells leaves the count alone
      do_reset();
      for (int i = 0; i < 78; i++) apply(4'h1, 4'h1, 4'h1, 1'b0);
      apply(4'h1, 4'h1, 4'h1, 1'b1);
      chk("cnt50_before", o_free_cnt, 8'd50);
      chk("cnt50_grant", o_grant, 4'h1);
      apply(4'h0, 4'h0, 4'h0, 1'b0);
      chk("cnt50_after", o_free_cnt, 8'd50);

      // Fill the buffer, then one release lets exactly one cell in at address 0
      do_reset();
      for (int i = 0; i < 128; i++) begin
         apply(4'h1, 4'h1, 4'h1, 1'b0);
         chk($sformatf("fill%0d_grant", i), o_grant, 4'h1);
      end
      apply(4'h1, 4'h1, 4'h1, 1'b1);
      chk("full_flag", o_full, 1'b1);
      chk("full_cnt", o_free_cnt, 8'd0);
      chk("full_grant", o_grant, 4'h0);
      chk("last_addr", o_wr_addr, 7'd127);
      apply(4'h1, 4'h1, 4'h1, 1'b0);
      chk("after_free_cnt", o_free_cnt, 8'd1);
      chk("after_free_full", o_full, 1'b0);
      chk("after_free_grant", o_grant, 4'h1);
      chk("after_free_wr_en", o_wr_en, 1'b0);
      apply(4'h1, 4'h1, 4'h1, 1'b0);
      chk("wrap_wr_en", o_wr_en, 1'b1);
      chk("wrap_addr", o_wr_addr, 7'd0);
      chk("wrap_full", o_full, 1'b1);
      chk("wrap_grant", o_grant, 4'h0);

      // Reset in the middle of a packet drops the lock
      do_reset();
      apply(4'h2, 4'h2, 4'h0, 1'b0);
      chk("mid_first_grant", o_grant, 4'h2);
      @(posedge clk_80M); #1;
      rst_n = 1'b0; i_sop = 4'h0; #1;
      chk("mid_busy", o_busy, 1'b1);
      chk("mid_rst_grant", o_grant, 4'h0);
      @(posedge clk_80M); #1;
      rst_n = 1'b1; #1;
      chk("post_rst_busy", o_busy, 1'b0);
      chk("post_rst_cnt", o_free_cnt, 8'd128);
      chk("post_rst_cont_grant", o_grant, 4'h0);
      apply(4'h2, 4'h2, 4'h0, 1'b0);
      chk("post_rst_sop_grant", o_grant, 4'h2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
